// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted conditional branches, from fetch to resolution.
// Define GHIST_EN to build gshare indexing (global history XORed into the table index).
module branch_resolve_queue #(
   parameter int DEPTH     = 4,
   parameter int PC_WIDTH  = 10,
   parameter int IDX_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   br_valid,
   output logic                   br_ready,
   input  logic [PC_WIDTH-1:0]    br_pc,
   input  logic [PC_WIDTH-1:0]    br_target,
   output logic [IDX_WIDTH-1:0]   tbl_addr,
   input  logic [1:0]             tbl_rec,
   output logic                   pred_taken,
   input  logic                   res_valid,
   input  logic                   res_taken,
   output logic                   upd_valid,
   output logic [IDX_WIDTH-1:0]   upd_addr,
   output logic                   upd_taken,
   output logic                   mispredict,
   output logic [PC_WIDTH-1:0]    redirect_pc,
   output logic [$clog2(DEPTH):0] count,
   output logic                   underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [IDX_WIDTH-1:0] ent_idx  [DEPTH];
   logic                 ent_pred [DEPTH];
   logic [PC_WIDTH-1:0]  ent_pc   [DEPTH];
   logic [PC_WIDTH-1:0]  ent_tgt  [DEPTH];

   logic [PW-1:0]        head;
   logic [PW-1:0]        tail;
   logic                 push;
   logic                 pop;
   logic                 mis;
   logic [IDX_WIDTH-1:0] h_idx;
   logic                 h_pred;
   logic [PC_WIDTH-1:0]  h_pc;
   logic [PC_WIDTH-1:0]  h_tgt;

   // Only the counter's direction bit feeds the prediction.
   logic tbl_rec_unused;
   assign tbl_rec_unused = tbl_rec[0];

`ifdef GHIST_EN
   logic [IDX_WIDTH-1:0] ghist;

   assign tbl_addr = br_pc[IDX_WIDTH-1:0] ^ ghist;

   // History is architectural: shifted only on real resolves, never rolled back on flush.
   always_ff @(posedge clk) begin
      if (rst)
         ghist <= '0;
      else if (pop)
         ghist <= {ghist[IDX_WIDTH-2:0], res_taken};
   end
`else
   assign tbl_addr = br_pc[IDX_WIDTH-1:0];
`endif

   assign br_ready   = (count != CW'(DEPTH));
   assign pred_taken = br_valid & tbl_rec[1];
   assign push       = br_valid & br_ready;
   assign pop        = res_valid & (count != '0);

   assign h_idx  = ent_idx[head];
   assign h_pred = ent_pred[head];
   assign h_pc   = ent_pc[head];
   assign h_tgt  = ent_tgt[head];
   assign mis    = pop & (h_pred != res_taken);

   always_ff @(posedge clk) begin
      if (rst) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         upd_valid   <= 1'b0;
         upd_addr    <= '0;
         upd_taken   <= 1'b0;
         mispredict  <= 1'b0;
         redirect_pc <= '0;
         underflow   <= 1'b0;
      end else begin
         upd_valid  <= pop;
         mispredict <= mis;
         if (pop) begin
            upd_addr    <= h_idx;
            upd_taken   <= res_taken;
            redirect_pc <= res_taken ? h_tgt : h_pc + PC_WIDTH'(1);
         end
         if (res_valid && count == '0)
            underflow <= 1'b1;

         // A mispredict squashes everything younger, including a same-cycle push.
         if (mis) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) begin
               ent_idx[tail]  <= tbl_addr;
               ent_pred[tail] <= tbl_rec[1];
               ent_pc[tail]   <= br_pc;
               ent_tgt[tail]  <= br_target;
               tail           <= tail + PW'(1);
            end
            if (pop)
               head <= head + PW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: one task per scenario, inline checks.
// The gshare scenario is compiled in only when GHIST_EN is defined.
module tb_branch_resolve_queue;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       br_valid = 1'b0;
   logic       br_ready;
   logic [9:0] br_pc = '0;
   logic [9:0] br_target = '0;
   logic [2:0] tbl_addr;
   logic [1:0] tbl_rec = '0;
   logic       pred_taken;
   logic       res_valid = 1'b0;
   logic       res_taken = 1'b0;
   logic       upd_valid;
   logic [2:0] upd_addr;
   logic       upd_taken;
   logic       mispredict;
   logic [9:0] redirect_pc;
   logic [2:0] count;
   logic       underflow;

   int n_checks = 0;
   int n_fail   = 0;

   branch_resolve_queue #(.DEPTH(4), .PC_WIDTH(10), .IDX_WIDTH(3)) dut (
      .clk(clk), .rst(rst),
      .br_valid(br_valid), .br_ready(br_ready), .br_pc(br_pc), .br_target(br_target),
      .tbl_addr(tbl_addr), .tbl_rec(tbl_rec), .pred_taken(pred_taken),
      .res_valid(res_valid), .res_taken(res_taken),
      .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .count(count), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; br_valid = 1'b0; res_valid = 1'b0; res_taken = 1'b0;
      br_pc = '0; br_target = '0; tbl_rec = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic push(input logic [9:0] pc, input logic [9:0] tgt, input logic [1:0] rec);
      br_valid = 1'b1; br_pc = pc; br_target = tgt; tbl_rec = rec;
      step();
      br_valid = 1'b0;
   endtask

   task automatic resolve(input logic taken);
      res_valid = 1'b1; res_taken = taken;
      step();
      res_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", br_ready); end
      n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid: got %b want 0", upd_valid); end
      n_checks++; if (upd_addr !== 3'd0 || upd_taken !== 1'b0) begin n_fail++; $display("FAIL reset_upd: got addr %0d taken %b want 0 0", upd_addr, upd_taken); end
      n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict: got %b want 0", mispredict); end
      n_checks++; if (redirect_pc !== 10'h000) begin n_fail++; $display("FAIL reset_redirect: got %h want 000", redirect_pc); end
      n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b want 0", underflow); end
   endtask

   task automatic test_mispredict_taken();
      do_reset();
      br_valid = 1'b1; br_pc = 10'h005; br_target = 10'h020; tbl_rec = 2'b00;
      #1;
      n_checks++; if (tbl_addr !== 3'd5) begin n_fail++; $display("FAIL mt_tbl_addr: got %0d want 5", tbl_addr); end
      n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL mt_pred: got %b want 0", pred_taken); end
      step();
      br_valid = 1'b0;
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL mt_count1: got %0d want 1", count); end
      resolve(1'b1);
      n_checks++; if (upd_valid !== 1'b1 || upd_addr !== 3'd5 || upd_taken !== 1'b1) begin n_fail++; $display("FAIL mt_update: got v%b a%0d t%b want v1 a5 t1", upd_valid, upd_addr, upd_taken); end
      n_checks++; if (mispredict !== 1'b1 || redirect_pc !== 10'h020) begin n_fail++; $display("FAIL mt_redirect: got m%b pc %h want m1 pc 020", mispredict, redirect_pc); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mt_count0: got %0d want 0", count); end
      step();
      n_checks++; if (upd_valid !== 1'b0 || mispredict !== 1'b0) begin n_fail++; $display("FAIL mt_pulse: got v%b m%b want v0 m0", upd_valid, mispredict); end
   endtask

   task automatic test_correct_predict();
      do_reset();
      br_valid = 1'b1; br_pc = 10'h00A; br_target = 10'h050; tbl_rec = 2'b11;
      #1;
      n_checks++; if (tbl_addr !== 3'd2 || pred_taken !== 1'b1) begin n_fail++; $display("FAIL cp_lookup: got a%0d p%b want a2 p1", tbl_addr, pred_taken); end
      step();
      br_valid = 1'b0;
      resolve(1'b1);
      n_checks++; if (upd_valid !== 1'b1 || upd_addr !== 3'd2 || upd_taken !== 1'b1) begin n_fail++; $display("FAIL cp_update: got v%b a%0d t%b want v1 a2 t1", upd_valid, upd_addr, upd_taken); end
      n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL cp_nomis: got %b want 0", mispredict); end
      do_reset();
      push(10'h00A, 10'h050, 2'b11);
      resolve(1'b0);
      n_checks++; if (upd_valid !== 1'b1 || upd_addr !== 3'd2 || upd_taken !== 1'b0) begin n_fail++; $display("FAIL cp_nt_update: got v%b a%0d t%b want v1 a2 t0", upd_valid, upd_addr, upd_taken); end
      n_checks++; if (mispredict !== 1'b1 || redirect_pc !== 10'h00B) begin n_fail++; $display("FAIL cp_nt_redirect: got m%b pc %h want m1 pc 00b", mispredict, redirect_pc); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 1; i <= 4; i++) push(10'(i), 10'h100, 2'b11);
      n_checks++; if (count !== 3'd4 || br_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got c%0d r%b want c4 r0", count, br_ready); end
      push(10'h007, 10'h200, 2'b00);
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_reject: got %0d want 4", count); end
      res_valid = 1'b1; res_taken = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         n_checks++;
         if (upd_valid !== 1'b1 || upd_addr !== 3'(i) || mispredict !== 1'b0) begin
            n_fail++; $display("FAIL full_drain%0d: got v%b a%0d m%b want v1 a%0d m0", i, upd_valid, upd_addr, mispredict, i);
         end
      end
      res_valid = 1'b0;
      n_checks++; if (count !== 3'd0 || br_ready !== 1'b1) begin n_fail++; $display("FAIL full_empty: got c%0d r%b want c0 r1", count, br_ready); end
      step();
      n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL full_idle: got %b want 0", upd_valid); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      push(10'h021, 10'h060, 2'b11);
      push(10'h022, 10'h061, 2'b11);
      br_valid = 1'b1; br_pc = 10'h023; br_target = 10'h062; tbl_rec = 2'b00;
      res_valid = 1'b1; res_taken = 1'b1;
      step();
      br_valid = 1'b0;
      n_checks++; if (count !== 3'd2 || upd_addr !== 3'd1 || mispredict !== 1'b0) begin n_fail++; $display("FAIL b2b_pushpop: got c%0d a%0d m%b want c2 a1 m0", count, upd_addr, mispredict); end
      step();
      n_checks++; if (upd_valid !== 1'b1 || upd_addr !== 3'd2 || mispredict !== 1'b0) begin n_fail++; $display("FAIL b2b_second: got v%b a%0d m%b want v1 a2 m0", upd_valid, upd_addr, mispredict); end
      step();
      res_valid = 1'b0;
      n_checks++; if (upd_valid !== 1'b1 || upd_addr !== 3'd3 || mispredict !== 1'b1 || redirect_pc !== 10'h062) begin n_fail++; $display("FAIL b2b_third: got v%b a%0d m%b pc %h want v1 a3 m1 pc 062", upd_valid, upd_addr, mispredict, redirect_pc); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_count: got %0d want 0", count); end
   endtask

   task automatic test_flush();
      do_reset();
      push(10'h010, 10'h040, 2'b00);
      push(10'h011, 10'h041, 2'b00);
      push(10'h012, 10'h042, 2'b00);
      n_checks++; if (count !== 3'd3 || br_ready !== 1'b1) begin n_fail++; $display("FAIL fl_fill: got c%0d r%b want c3 r1", count, br_ready); end
      br_valid = 1'b1; br_pc = 10'h013; br_target = 10'h043; tbl_rec = 2'b00;
      res_valid = 1'b1; res_taken = 1'b1;
      step();
      br_valid = 1'b0; res_valid = 1'b0;
      n_checks++; if (count !== 3'd0 || mispredict !== 1'b1 || redirect_pc !== 10'h040 || upd_addr !== 3'd0) begin n_fail++; $display("FAIL fl_flush: got c%0d m%b pc %h a%0d want c0 m1 pc 040 a0", count, mispredict, redirect_pc, upd_addr); end
      resolve(1'b0);
      n_checks++; if (upd_valid !== 1'b0 || mispredict !== 1'b0 || underflow !== 1'b1) begin n_fail++; $display("FAIL fl_underflow: got v%b m%b u%b want v0 m0 u1", upd_valid, mispredict, underflow); end
      step();
      step();
      n_checks++; if (underflow !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL fl_sticky: got u%b c%0d want u1 c0", underflow, count); end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      push(10'h3FF, 10'h100, 2'b10);
      resolve(1'b0);
      n_checks++; if (mispredict !== 1'b1 || redirect_pc !== 10'h000 || upd_addr !== 3'd7) begin n_fail++; $display("FAIL wrap_redirect: got m%b pc %h a%0d want m1 pc 000 a7", mispredict, redirect_pc, upd_addr); end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      push(10'h031, 10'h070, 2'b11);
      push(10'h032, 10'h071, 2'b11);
      rst = 1'b1; res_valid = 1'b1; res_taken = 1'b0; br_valid = 1'b1;
      step();
      rst = 1'b0; res_valid = 1'b0; br_valid = 1'b0;
      n_checks++; if (count !== 3'd0 || upd_valid !== 1'b0 || mispredict !== 1'b0) begin n_fail++; $display("FAIL rm_clear: got c%0d v%b m%b want c0 v0 m0", count, upd_valid, mispredict); end
      resolve(1'b1);
      n_checks++; if (upd_valid !== 1'b0 || underflow !== 1'b1) begin n_fail++; $display("FAIL rm_discard: got v%b u%b want v0 u1", upd_valid, underflow); end
   endtask

`ifdef GHIST_EN
   task automatic test_ghist();
      do_reset();
      push(10'h000, 10'h080, 2'b00);
      resolve(1'b1);
      push(10'h000, 10'h080, 2'b00);
      resolve(1'b1);
      push(10'h000, 10'h080, 2'b00);
      resolve(1'b0);
      br_valid = 1'b1; br_pc = 10'h001; br_target = 10'h090; tbl_rec = 2'b11;
      #1;
      n_checks++; if (tbl_addr !== 3'b111) begin n_fail++; $display("FAIL gh_index: got %b want 111", tbl_addr); end
      step();
      br_valid = 1'b0;
      resolve(1'b1);
      n_checks++; if (upd_valid !== 1'b1 || upd_addr !== 3'd7) begin n_fail++; $display("FAIL gh_update: got v%b a%0d want v1 a7", upd_valid, upd_addr); end
   endtask
`endif

   initial begin
      test_reset();
      test_mispredict_taken();
      test_correct_predict();
      test_full();
      test_back_to_back();
      test_flush();
      test_pc_wrap();
      test_reset_midflight();
`ifdef GHIST_EN
      test_ghist();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks every conditional branch between prediction at fetch and resolution at execute in the pipelined RAT core. It drives the read index of the 2-bit saturating-counter prediction table and turns the returned counter into a taken/not-taken prediction. It buffers each prediction in order, and at resolution issues the table update and a mispredict redirect. The queue is flushed on a mispredict.

## Interface
Parameters:
- DEPTH, 4, maximum in-flight unresolved branches; power of two, 2..8.
- PC_WIDTH, 10, program counter width.
- IDX_WIDTH, 3, prediction table index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- br_valid  input  1  fetch presents a conditional branch this cycle.
- br_ready  output  1  queue can accept a branch; high when count != DEPTH.
- br_pc  input  PC_WIDTH  PC of the branch.
- br_target  input  PC_WIDTH  taken target of the branch.
- tbl_addr  output  IDX_WIDTH  prediction table read index (combinational).
- tbl_rec  input  2  counter read from the table at tbl_addr (same cycle).
- pred_taken  output  1  combinational; equals br_valid & tbl_rec[1].
- res_valid  input  1  execute resolves the oldest branch this cycle.
- res_taken  input  1  actual direction of the resolved branch.
- upd_valid  output  1  table update strobe; connects to the table's update input.
- upd_addr  output  IDX_WIDTH  index to update; connects to wr_addr.
- upd_taken  output  1  direction to train toward; connects to taken.
- mispredict  output  1  one-cycle pulse that flushes the younger pipeline stages.
- redirect_pc  output  PC_WIDTH  corrected fetch PC; valid while mispredict is high.
- count  output  $clog2(DEPTH)+1  current occupancy.
- underflow  output  1  sticky; set when a resolve arrives while the queue is empty.

## Operation
- Index: tbl_addr = br_pc[IDX_WIDTH-1:0]. With GHIST_EN, the index is XORed with the global history.
- Push: on br_valid & br_ready, write an entry {idx=tbl_addr, pred=tbl_rec[1], pc=br_pc, target=br_target} at the tail and advance the tail. The tail pointer wraps modulo DEPTH.
- Pop: on res_valid with count != 0, read the head entry and advance the head with wrap.
- On each pop the next cycle drives:
  - upd_valid=1, upd_addr=entry.idx, upd_taken=res_taken.
  - If entry.pred != res_taken: mispredict=1.
  - redirect_pc = res_taken ? entry.target : entry.pc+1. The increment is truncated to PC_WIDTH, so 0x3FF+1 = 0x000.
- Mispredict flush: all entries younger than the popped one are wrong-path. Head, tail and count are all set to 0 at the same clock edge as the mispredicting pop.
- Push and pop in the same cycle without mispredict: the entry is written, the head advances, and count is unchanged.
- Push and mispredicting pop in the same cycle: the pushed entry is discarded and count becomes 0.
- Full (count == DEPTH): br_ready=0, and a branch presented with br_valid is not accepted. br_ready does not depend on a same-cycle pop; there is no bypass.
- Resolve while empty: no update and no mispredict. underflow is set and stays set until rst.

## Timing
- tbl_addr, pred_taken and br_ready are combinational from inputs and state, with zero latency. The table read is combinational, so the prediction is available in the fetch cycle.
- upd_valid, upd_addr, upd_taken, mispredict and redirect_pc are registered. They are valid exactly one cycle after the res_valid cycle and are high for one cycle per pop.
- Back-to-back resolves produce back-to-back update pulses.
- Reset values: count=0, head=tail=0, upd_valid=0, upd_addr=0, upd_taken=0, mispredict=0, redirect_pc=0, underflow=0, global history=0.
- rst has priority over every push and pop in the same cycle. Entries held when rst is asserted mid-operation are discarded, and no update or mispredict is emitted for them.

## Configuration
- GHIST_EN defined: gshare indexing.
  - A global history register of width IDX_WIDTH is updated at every valid pop: ghist <= {ghist[IDX_WIDTH-2:0], res_taken}.
  - The history is not speculative and is not restored on flush.
  - tbl_addr = br_pc[IDX_WIDTH-1:0] ^ ghist. The stored entry.idx is the XORed value, so the update hits the same counter that was read.
- GHIST_EN undefined: no history register is built, and tbl_addr = br_pc[IDX_WIDTH-1:0].

## Test plan
- Reset, then push pc=0x005, target=0x020, tbl_rec=2'b00. Resolve res_taken=1 -> next cycle: upd_addr=5, upd_taken=1, mispredict=1, redirect_pc=0x020.
- Push pc=0x00A with tbl_rec=2'b11, resolve res_taken=1 -> upd_addr=2, upd_taken=1, mispredict=0. Repeat with res_taken=0 -> mispredict=1, redirect_pc=0x00B.
- Push 4 branches -> count=4, br_ready=0. A 5th push is ignored. Then resolve all 4 correctly in order -> 4 consecutive update pulses with matching indices, and count=0.
- Queue holds 3 entries. Resolve the oldest with a mispredict while a push occurs in the same cycle -> count=0 next cycle, and later resolves set underflow=1 with no upd_valid.
- Push pc=0x3FF predicted taken, resolve not taken -> redirect_pc=0x000.
- GHIST_EN: resolve taken, taken, not-taken (ghist=3'b110), then push pc=0x001 -> tbl_addr=3'b111, and the later update has upd_addr=7.
